// File: rtl/ob_sorted_table.sv
// Price-sorted resting-order table for one book side: single-cycle insert/cancel/amend/fill.
// Optional duplicate-UID rejection on INSERT when OB_SORTED_TABLE_DUP_CHECK_EN is defined.
module ob_sorted_table #(
    parameter int N       = 16,
    parameter int IS_ASK  = 1,
    parameter int PRICE_W = 20,
    parameter int QTY_W   = 16,
    parameter int UID_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [1:0]               cmd_op,
    input  logic [UID_W-1:0]         cmd_uid,
    input  logic [PRICE_W-1:0]       cmd_price,
    input  logic [QTY_W-1:0]         cmd_qty,
    output logic                     rsp_vld,
    output logic [1:0]               rsp_status,
    output logic [UID_W-1:0]         rsp_uid,
    output logic [QTY_W-1:0]         rsp_qty,
    output logic                     head_vld,
    output logic [UID_W-1:0]         head_uid,
    output logic [PRICE_W-1:0]       head_price,
    output logic [QTY_W-1:0]         head_qty,
    output logic [$clog2(N+1)-1:0]   cnt,
    output logic                     reject_vld,
    output logic [UID_W-1:0]         reject_uid,
    output logic [PRICE_W-1:0]       reject_price,
    output logic [QTY_W-1:0]         reject_qty,
    input  logic                     reject_pop
);
    localparam int CW = $clog2(N+1);
    localparam int IW = $clog2(N);

    localparam logic [1:0] OP_INSERT = 2'd0, OP_CANCEL = 2'd1, OP_AMEND = 2'd2, OP_FILL = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_SPILL = 2'd2, ST_DUP = 2'd3;

    logic [N-1:0]       vld_q, vld_d;
    logic [UID_W-1:0]   uid_q   [N];
    logic [UID_W-1:0]   uid_d   [N];
    logic [PRICE_W-1:0] price_q [N];
    logic [PRICE_W-1:0] price_d [N];
    logic [QTY_W-1:0]   qty_q   [N];
    logic [QTY_W-1:0]   qty_d   [N];
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               rsp_vld_q, rsp_vld_d;
    logic [1:0]         rsp_status_q, rsp_status_d;
    logic [UID_W-1:0]   rsp_uid_q, rsp_uid_d;
    logic [QTY_W-1:0]   rsp_qty_q, rsp_qty_d;
    logic               rej_vld_q, rej_vld_d;
    logic [UID_W-1:0]   rej_uid_q, rej_uid_d;
    logic [PRICE_W-1:0] rej_price_q, rej_price_d;
    logic [QTY_W-1:0]   rej_qty_q, rej_qty_d;

    logic [N-1:0]       worse, hit;
    logic [IW-1:0]      ins_pos, hit_pos, rm_pos;
    logic               ins_found, hit_any, full, ins_en, rm_en;

    // Entries are packed and sorted, so the "worse" mask is a contiguous tail run.
    always_comb begin
        worse   = '0;
        hit     = '0;
        ins_pos = IW'(cnt_q);
        hit_pos = '0;
        for (int i = 0; i < N; i++) begin
            worse[i] = vld_q[i] && ((IS_ASK != 0) ? (cmd_price < price_q[i]) : (cmd_price > price_q[i]));
            hit[i]   = vld_q[i] && (uid_q[i] == cmd_uid);
        end
        for (int i = N-1; i >= 0; i--) begin
            if (worse[i]) ins_pos = IW'(i);
            if (hit[i])   hit_pos = IW'(i);
        end
    end

    assign ins_found = |worse;
    assign hit_any   = |hit;
    assign full      = (cnt_q == CW'(N));
    assign cmd_rdy   = !rst && !rej_vld_q;

    always_comb begin
        vld_d = vld_q; uid_d = uid_q; price_d = price_q; qty_d = qty_q; cnt_d = cnt_q;
        rsp_vld_d = 1'b0; rsp_status_d = ST_OK; rsp_uid_d = '0; rsp_qty_d = '0;
        rej_vld_d = rej_vld_q; rej_uid_d = rej_uid_q; rej_price_d = rej_price_q; rej_qty_d = rej_qty_q;
        ins_en = 1'b0; rm_en = 1'b0; rm_pos = '0;

        if (reject_pop) rej_vld_d = 1'b0;

        if (cmd_vld && cmd_rdy) begin
            rsp_vld_d = 1'b1;
            case (cmd_op)
                OP_INSERT: begin
                    rsp_uid_d = cmd_uid;
`ifdef OB_SORTED_TABLE_DUP_CHECK_EN
                    if (hit_any) rsp_status_d = ST_DUP;
                    else
`endif
                    if (full && !ins_found) begin
                        rsp_status_d = ST_SPILL;
                        rsp_qty_d    = cmd_qty;
                        rej_vld_d = 1'b1; rej_uid_d = cmd_uid; rej_price_d = cmd_price; rej_qty_d = cmd_qty;
                    end else begin
                        ins_en = 1'b1;
                        if (full) begin
                            rsp_status_d = ST_SPILL;
                            rsp_uid_d    = uid_q[N-1];
                            rsp_qty_d    = qty_q[N-1];
                            rej_vld_d = 1'b1; rej_uid_d = uid_q[N-1]; rej_price_d = price_q[N-1]; rej_qty_d = qty_q[N-1];
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                OP_CANCEL, OP_AMEND: begin
                    rsp_uid_d = cmd_uid;
                    if (cmd_op == OP_AMEND && cmd_qty == '0) begin
                        rsp_status_d = ST_OK;
                    end else if (!hit_any) begin
                        rsp_status_d = ST_MISS;
                    end else if (cmd_op == OP_CANCEL || cmd_qty >= qty_q[hit_pos]) begin
                        rsp_qty_d = qty_q[hit_pos];
                        rm_en = 1'b1; rm_pos = hit_pos;
                    end else begin
                        rsp_qty_d = cmd_qty;
                        qty_d[hit_pos] = qty_q[hit_pos] - cmd_qty;
                    end
                end
                default: begin
                    rsp_uid_d = uid_q[0];
                    if (cmd_qty == '0) begin
                        rsp_status_d = ST_OK;
                    end else if (!vld_q[0]) begin
                        rsp_status_d = ST_MISS;
                    end else if (cmd_qty >= qty_q[0]) begin
                        // Excess fill beyond the head quantity is dropped.
                        rsp_qty_d = qty_q[0];
                        rm_en = 1'b1;
                    end else begin
                        rsp_qty_d = cmd_qty;
                        qty_d[0]  = qty_q[0] - cmd_qty;
                    end
                end
            endcase
        end

        if (ins_en) begin
            for (int i = 1; i < N; i++) begin
                if (IW'(i) > ins_pos) begin
                    vld_d[i] = vld_q[i-1]; uid_d[i] = uid_q[i-1]; price_d[i] = price_q[i-1]; qty_d[i] = qty_q[i-1];
                end
            end
            vld_d[ins_pos] = 1'b1; uid_d[ins_pos] = cmd_uid; price_d[ins_pos] = cmd_price; qty_d[ins_pos] = cmd_qty;
        end

        if (rm_en) begin
            for (int i = 0; i < N-1; i++) begin
                if (IW'(i) >= rm_pos) begin
                    vld_d[i] = vld_q[i+1]; uid_d[i] = uid_q[i+1]; price_d[i] = price_q[i+1]; qty_d[i] = qty_q[i+1];
                end
            end
            vld_d[N-1] = 1'b0; uid_d[N-1] = '0; price_d[N-1] = '0; qty_d[N-1] = '0;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < N; i++) begin
                uid_q[i] <= '0; price_q[i] <= '0; qty_q[i] <= '0;
            end
            cnt_q <= '0;
            rsp_vld_q <= 1'b0; rsp_status_q <= ST_OK; rsp_uid_q <= '0; rsp_qty_q <= '0;
            rej_vld_q <= 1'b0; rej_uid_q <= '0; rej_price_q <= '0; rej_qty_q <= '0;
        end else begin
            vld_q <= vld_d; uid_q <= uid_d; price_q <= price_d; qty_q <= qty_d;
            cnt_q <= cnt_d;
            rsp_vld_q <= rsp_vld_d; rsp_status_q <= rsp_status_d; rsp_uid_q <= rsp_uid_d; rsp_qty_q <= rsp_qty_d;
            rej_vld_q <= rej_vld_d; rej_uid_q <= rej_uid_d; rej_price_q <= rej_price_d; rej_qty_q <= rej_qty_d;
        end
    end

    assign rsp_vld      = rsp_vld_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_uid      = rsp_uid_q;
    assign rsp_qty      = rsp_qty_q;
    assign head_vld     = vld_q[0];
    assign head_uid     = uid_q[0];
    assign head_price   = price_q[0];
    assign head_qty     = qty_q[0];
    assign cnt          = cnt_q;
    assign reject_vld   = rej_vld_q;
    assign reject_uid   = rej_uid_q;
    assign reject_price = rej_price_q;
    assign reject_qty   = rej_qty_q;

endmodule

// File: tb/tb_ob_sorted_table.sv
// Directed bench for ob_sorted_table (ask side, N=4) with a response scoreboard.
module tb_ob_sorted_table;
    localparam int N = 4, PW = 20, QW = 16, UW = 32, CW = $clog2(N+1);
    localparam logic [1:0] OP_INSERT = 2'd0, OP_CANCEL = 2'd1, OP_AMEND = 2'd2, OP_FILL = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_SPILL = 2'd2, ST_DUP = 2'd3;

    logic clk = 1'b0, rst;
    logic cmd_vld, cmd_rdy, rsp_vld, head_vld, reject_vld, reject_pop;
    logic [1:0] cmd_op, rsp_status;
    logic [UW-1:0] cmd_uid, rsp_uid, head_uid, reject_uid;
    logic [PW-1:0] cmd_price, head_price, reject_price;
    logic [QW-1:0] cmd_qty, rsp_qty, head_qty, reject_qty;
    logic [CW-1:0] cnt;

    ob_sorted_table #(.N(N), .IS_ASK(1), .PRICE_W(PW), .QTY_W(QW), .UID_W(UW)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_uid(cmd_uid), .cmd_price(cmd_price), .cmd_qty(cmd_qty),
        .rsp_vld(rsp_vld), .rsp_status(rsp_status), .rsp_uid(rsp_uid), .rsp_qty(rsp_qty),
        .head_vld(head_vld), .head_uid(head_uid), .head_price(head_price), .head_qty(head_qty),
        .cnt(cnt), .reject_vld(reject_vld), .reject_uid(reject_uid), .reject_price(reject_price),
        .reject_qty(reject_qty), .reject_pop(reject_pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    st;
        logic [UW-1:0] uid;
        logic [QW-1:0] qty;
        bit            cu;
        bit            cq;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Responses are compared in order against what each accepted command should produce.
    always @(negedge clk) begin
        if (rsp_vld === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
            end else begin
                got = sb.pop_front();
                chk("rsp_status", 64'(rsp_status), 64'(got.st));
                if (got.cu) chk("rsp_uid", 64'(rsp_uid), 64'(got.uid));
                if (got.cq) chk("rsp_qty", 64'(rsp_qty), 64'(got.qty));
            end
        end
    end

    task automatic cmd(input logic [1:0] op, input int uid, input int price, input int qty,
                       input logic [1:0] st, input int ruid, input int rqty,
                       input bit cu, input bit cq, input bit acc);
        exp_t e;
        @(negedge clk);
        cmd_vld = 1'b1; cmd_op = op; cmd_uid = UW'(uid); cmd_price = PW'(price); cmd_qty = QW'(qty);
        reject_pop = 1'b0;
        if (acc) begin
            e.st = st; e.uid = UW'(ruid); e.qty = QW'(rqty); e.cu = cu; e.cq = cq;
            sb.push_back(e);
        end
    endtask

    task automatic ins(input int uid, input int price, input int qty);
        cmd(OP_INSERT, uid, price, qty, ST_OK, uid, 0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_vld = 1'b0; reject_pop = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        cmd_vld = 1'b0; reject_pop = 1'b1;
        @(negedge clk);
        reject_pop = 1'b0;
    endtask

    task automatic chk_head(input int uid, input int price, input int qty, input int n);
        chk("head_vld", 64'(head_vld), 64'd1);
        chk("head_uid", 64'(head_uid), 64'(uid));
        chk("head_price", 64'(head_price), 64'(price));
        chk("head_qty", 64'(head_qty), 64'(qty));
        chk("cnt", 64'(cnt), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; reject_pop = 1'b0;
        cmd_op = '0; cmd_uid = '0; cmd_price = '0; cmd_qty = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 64'(cmd_rdy), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_head_vld", 64'(head_vld), 64'd0);
        chk("rst_reject_vld", 64'(reject_vld), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 64'(cmd_rdy), 64'd1);
        chk("post_rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("post_rst_head_uid", 64'(head_uid), 64'd0);

        // Ask ordering with time priority at equal price
        ins(1, 105, 11); ins(2, 100, 50); ins(3, 103, 30); ins(4, 100, 10);
        idle();
        chk_head(2, 100, 50, 4);

        // Better price into a full table spills the tail
        cmd(OP_INSERT, 5, 101, 7, ST_SPILL, 1, 0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("spill_rej_vld", 64'(reject_vld), 64'd1);
        chk("spill_rej_uid", 64'(reject_uid), 64'd1);
        chk("spill_rej_price", 64'(reject_price), 64'd105);
        chk("spill_rej_qty", 64'(reject_qty), 64'd11);
        chk("spill_rdy", 64'(cmd_rdy), 64'd0);
        chk_head(2, 100, 50, 4);
        idle();
        chk("spill_rdy_hold", 64'(cmd_rdy), 64'd0);
        pop();
        chk("pop_rej_vld", 64'(reject_vld), 64'd0);
        chk("pop_rdy", 64'(cmd_rdy), 64'd1);

        // Worse price, and equal-to-tail price, go straight to the reject slot
        cmd(OP_INSERT, 6, 200, 9, ST_SPILL, 6, 0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("direct_rej_uid", 64'(reject_uid), 64'd6);
        chk("direct_rej_price", 64'(reject_price), 64'd200);
        chk("direct_rej_qty", 64'(reject_qty), 64'd9);
        chk_head(2, 100, 50, 4);
        pop();
        cmd(OP_INSERT, 7, 103, 1, ST_SPILL, 7, 0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("eq_tail_rej_uid", 64'(reject_uid), 64'd7);
        chk("eq_tail_cnt", 64'(cnt), 64'd4);
        pop();

        // Fill: partial, then overfill pops the head, then zero fill
        cmd(OP_FILL, 0, 0, 20, ST_OK, 2, 20, 1'b1, 1'b1, 1'b1);
        idle();
        chk("fill_part_qty", 64'(head_qty), 64'd30);
        cmd(OP_FILL, 0, 0, 40, ST_OK, 2, 30, 1'b1, 1'b1, 1'b1);
        idle();
        chk_head(4, 100, 10, 3);
        cmd(OP_FILL, 0, 0, 0, ST_OK, 0, 0, 1'b0, 1'b1, 1'b1);
        idle();
        chk_head(4, 100, 10, 3);

        // Cancel mid-table, amend miss / full removal / partial
        cmd(OP_CANCEL, 5, 0, 0, ST_OK, 5, 7, 1'b1, 1'b1, 1'b1);
        idle();
        chk_head(4, 100, 10, 2);
        cmd(OP_AMEND, 99, 0, 3, ST_MISS, 99, 0, 1'b0, 1'b1, 1'b1);
        cmd(OP_AMEND, 4, 0, 10, ST_OK, 4, 10, 1'b1, 1'b1, 1'b1);
        idle();
        chk_head(3, 103, 30, 1);
        cmd(OP_AMEND, 3, 0, 5, ST_OK, 3, 5, 1'b1, 1'b1, 1'b1);
        cmd(OP_CANCEL, 42, 0, 0, ST_MISS, 42, 0, 1'b0, 1'b1, 1'b1);
        idle();
        chk_head(3, 103, 25, 1);
        cmd(OP_FILL, 0, 0, 100, ST_OK, 3, 25, 1'b1, 1'b1, 1'b1);
        cmd(OP_FILL, 0, 0, 5, ST_MISS, 0, 0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("empty_head_vld", 64'(head_vld), 64'd0);
        chk("empty_cnt", 64'(cnt), 64'd0);

        // Zero-qty insert rests; a fill against it reports zero and pops it
        ins(8, 50, 0); ins(9, 50, 3);
        idle();
        chk_head(8, 50, 0, 2);
        cmd(OP_FILL, 0, 0, 4, ST_OK, 8, 0, 1'b1, 1'b1, 1'b1);
        idle();
        chk_head(9, 50, 3, 1);

        // Back-to-back with reset arriving on the third command
        ins(10, 60, 1); ins(11, 40, 2);
        @(negedge clk);
        rst = 1'b1; cmd_vld = 1'b1; cmd_op = OP_INSERT; cmd_uid = 32'd12; cmd_price = 20'd30; cmd_qty = 16'd1;
        @(negedge clk);
        cmd_uid = 32'd13; cmd_price = 20'd20;
        chk("b2b_rst_rsp_vld", 64'(rsp_vld), 64'd0);
        idle();
        chk("b2b_rst_cnt", 64'(cnt), 64'd0);
        chk("b2b_rst_head_vld", 64'(head_vld), 64'd0);
        chk("b2b_rst_head_uid", 64'(head_uid), 64'd0);
        chk("b2b_rst_reject_vld", 64'(reject_vld), 64'd0);
        chk("b2b_rst_rdy", 64'(cmd_rdy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("b2b_post_rdy", 64'(cmd_rdy), 64'd1);
        ins(20, 10, 4);
        idle();
        chk_head(20, 10, 4, 1);
`ifdef OB_SORTED_TABLE_DUP_CHECK_EN
        cmd(OP_INSERT, 20, 5, 2, ST_DUP, 20, 0, 1'b1, 1'b0, 1'b1);
        idle();
        chk_head(20, 10, 4, 1);
`endif
        idle();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
